// File: rtl/test_case_pkg.sv
// Shared definitions for the binary-to-one-hot decoder.
package test_case_pkg;

   localparam int DEFAULT_IN_W  = 3;
   localparam int DEFAULT_OUT_W = 2 ** DEFAULT_IN_W;

   // One-hot decode at the default width: bit k set when a == k, zero when a
   // is not a clean binary code.
   function automatic logic [DEFAULT_OUT_W-1:0] onehot_f(input logic [DEFAULT_IN_W-1:0] a);
      logic [DEFAULT_OUT_W-1:0] res;
      res = '0;
      for (int k = 0; k < DEFAULT_OUT_W; k++) begin
         if (a == DEFAULT_IN_W'(k)) res[k] = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// Purely combinational binary-to-one-hot decode stage.
module onehot_dec #(
   parameter int IN_W = 3,
   localparam int OUT_W = 2 ** IN_W
) (
   input  logic [IN_W-1:0]  a,
   output logic [OUT_W-1:0] y
);

   // Compare a against every code; an unknown a matches nothing, so y stays zero.
   always_comb begin
      // NOTE: the all-zero default written first keeps every path assigned, so no latch is inferred.
      y = '0;
      for (int k = 0; k < OUT_W; k++) begin
         if (a == IN_W'(k)) y[k] = 1'b1;
      end
   end

endmodule

// File: rtl/test_case.sv
// Registered binary-to-one-hot decoder (default 3-to-8) with optional
// combinational bypass.
module test_case
   import test_case_pkg::*;
#(
   parameter int IN_W    = DEFAULT_IN_W,
   parameter bit REG_OUT = 1'b1,
   localparam int OUT_W  = 2 ** IN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  a,
   output logic [OUT_W-1:0] y
);

   logic [OUT_W-1:0] next_y;
   logic             loaded;
   logic             dec_hit;

   onehot_dec #(.IN_W(IN_W)) u_dec (
      .a (a),
      .y (next_y)
   );

   generate
      if (REG_OUT) begin : g_reg
         logic [OUT_W-1:0] y_q;

         // Output register: cleared asynchronously, loads the decode on every edge.
         always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (!rst_n) y_q <= '0;
            else        y_q <= next_y;
         end

         assign y = y_q;
      end else begin : g_comb
         assign y = rst_n ? next_y : '0;
      end
   endgenerate

   // Tracks whether y has been loaded since reset and whether that load was a clean code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loaded  <= 1'b0;
         dec_hit <= 1'b0;
      end else begin
         loaded  <= 1'b1;
         dec_hit <= |next_y;
      end
   end

   // Out of reset, once loaded from a decodable code, y carries exactly one set bit.
   a_onehot : assert property (@(negedge clk) disable iff (!rst_n)
      (loaded && dec_hit) |-> $onehot(y));

endmodule

// File: tb/tb_test_case.sv
// Self-checking bench for the registered 3-to-8 one-hot decoder.
module tb_test_case;

   logic       clk;
   logic       rst_n;
   logic [2:0] a;
   logic [7:0] y;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_y;

   test_case dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .y     (y)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference decode straight from the rule y = 1 << a; unknown input gives zero.
   function automatic logic [7:0] ref_dec(input logic [2:0] v);
      if ($isunknown(v)) return 8'h00;
      return 8'(1) << v;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: y=%b expected %b", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge and update the expected output.
   task automatic tick();
      @(posedge clk);
      exp_y = rst_n ? ref_dec(a) : 8'h00;
      #1;
   endtask

   initial begin
      int eight;
      logic [7:0] held;
      rst_n = 1'b0;
      a     = 3'b101;
      exp_y = 8'h00;

      // Reset asserted before any clock edge: y must already be zero.
      #3;
      check("reset_no_edge", y, 8'h00);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_hold", y, 8'h00);
      end

      // Release between edges; next edge loads decode of 101.
      #3 rst_n = 1'b1;
      #1 check("release_before_edge", y, 8'h00);
      tick();
      check("release_load", y, 8'b0010_0000);

      // Exhaustive sweep with one-cycle latency.
      for (int i = 0; i < 8; i++) begin
         a = 3'(i);
         tick();
         check("sweep", y, exp_y);
         check("sweep_table", y, 8'h01 << i);
      end

      // Integer 8 truncated onto a 3-bit select wraps to code 0.
      eight = 8;
      a = eight[2:0];
      tick();
      check("trunc_wrap", y, 8'b0000_0001);

      // Mid-cycle change of a must not reach y until the next edge.
      a = 3'b010;
      tick();
      check("hold_before", y, 8'b0000_0100);
      #2 a = 3'b110;
      #2 check("hold_mid", y, 8'b0000_0100);
      tick();
      check("hold_after", y, 8'b0100_0000);

      // Asynchronous reset pulse between edges.
      a = 3'b011;
      tick();
      check("pre_async", y, 8'b0000_1000);
      #2 rst_n = 1'b0;
      #1 check("async_clear", y, 8'h00);
      #2 rst_n = 1'b1;
      #1 check("async_released_no_edge", y, 8'h00);
      tick();
      check("async_resume", y, 8'b0000_1000);

      // Non-decodable select: y must carry no unknown bits and decode to zero.
      a = 3'b1x0;
      tick();
      check("unknown_no_x", {7'b0, $isunknown(y)}, 8'h00);
      check("unknown_decode", y, exp_y);

      // Randomised run with occasional asynchronous reset pulses.
      for (int i = 0; i < 300; i++) begin
         a = 3'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            held = y;
            #1 rst_n = 1'b0;
            #1 check("rand_async_clear", y, 8'h00);
            #1 rst_n = 1'b1;
            exp_y = 8'h00;
         end
         tick();
         check("rand_decode", y, exp_y);
         check("rand_onehot", {7'b0, $onehot(y)}, 8'h01);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
